// File: rtl/mem_port_arbiter.sv
// Arbitrates a single MEM-stage memory/I/O port between the CPU pipeline and a
// level-held loader/debug requester, with a bounded-starvation guarantee for the loader.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        ld_req,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  input  logic [31:0] dataout,
  output logic        mwmem,
  output logic [31:0] malu,
  output logic [31:0] mb,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  output logic        ld_ack,
  output logic [31:0] ld_rdata
);

  typedef enum logic [0:0] {StIdle, StAck} state_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] ld_rdata_q, ld_rdata_d;

  logic ld_elig;
  logic ld_gnt;
  logic cpu_gnt;

  // Grant decision; the loader is never eligible while reset is held.
  always_comb begin
    ld_elig = resetn & (state_q == StIdle) & ld_req;
    ld_gnt  = ld_elig & (~cpu_req | (starve_q == StarveMax));
    cpu_gnt = cpu_req & ~ld_gnt;
  end

  // Shared port drive; with no grant the CPU values stay on the bus but nothing is written.
  always_comb begin
    malu      = cpu_addr;
    mb        = cpu_wdata;
    mwmem     = 1'b0;
    cpu_rdata = 32'h0;
    if (ld_gnt) begin
      malu  = ld_addr;
      mb    = ld_wdata;
      mwmem = ld_we;
    end else if (cpu_gnt) begin
      mwmem     = cpu_we;
      cpu_rdata = dataout;
    end
    cpu_stall = cpu_req & ~cpu_gnt;
  end

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    ld_rdata_d = ld_rdata_q;
    unique case (state_q)
      StIdle: if (ld_gnt) state_d = StAck;
      StAck:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (ld_gnt) begin
      starve_d   = 4'd0;
      ld_rdata_d = dataout;
    end else if (ld_elig && cpu_gnt && (starve_q < StarveMax)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      starve_q   <= 4'd0;
      ld_rdata_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      ld_rdata_q <= ld_rdata_d;
    end
  end

  // Ack comes straight from the state flop so an asynchronous reset drops it at once.
  assign ld_ack   = (state_q == StAck);
  assign ld_rdata = ld_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle reference model checked on every
// falling edge, plus hand-computed literal expectations for the key scenarios.
module tb_mem_port_arbiter;

  localparam int unsigned SM = 4;

  logic        clock = 1'b0;
  logic        resetn;
  logic        cpu_req, cpu_we, ld_req, ld_we;
  logic [31:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata, dataout;
  logic        mwmem, cpu_stall, ld_ack;
  logic [31:0] malu, mb, cpu_rdata, ld_rdata;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.STARVE_MAX(SM)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .ld_req    (ld_req),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .dataout   (dataout),
    .mwmem     (mwmem),
    .malu      (malu),
    .mb        (mb),
    .cpu_stall (cpu_stall),
    .cpu_rdata (cpu_rdata),
    .ld_ack    (ld_ack),
    .ld_rdata  (ld_rdata)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference model: loader-outstanding flag, starvation count, loader read register.
  logic        m_ack = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_rdata = 32'h0;
  logic        nx_ld = 1'b0;
  logic        nx_inc = 1'b0;
  logic [31:0] nx_dout = 32'h0;
  logic        prev_ack = 1'b0;

  always @(negedge clock) begin : cmp
    logic        e_elig, e_ld, e_cpu, e_we;
    logic [31:0] e_addr, e_data, e_rd;
    e_elig = resetn && !m_ack && ld_req;
    e_ld   = e_elig && (!cpu_req || (m_cnt == int'(SM)));
    e_cpu  = cpu_req && !e_ld;
    e_we   = e_ld ? ld_we : (e_cpu && cpu_we);
    e_addr = e_ld ? ld_addr : cpu_addr;
    e_data = e_ld ? ld_wdata : cpu_wdata;
    e_rd   = e_cpu ? dataout : 32'h0;
    chk("m_mwmem", {31'b0, mwmem}, {31'b0, e_we});
    chk("m_malu", malu, e_addr);
    chk("m_mb", mb, e_data);
    chk("m_stall", {31'b0, cpu_stall}, {31'b0, cpu_req && !e_cpu});
    chk("m_cpu_rdata", cpu_rdata, e_rd);
    chk("m_ld_ack", {31'b0, ld_ack}, {31'b0, m_ack});
    chk("m_ld_rdata", ld_rdata, m_rdata);
    if (ld_ack) chk("no_double_ack", {31'b0, prev_ack}, 32'h0);
    prev_ack <= ld_ack;
    nx_ld    <= e_ld;
    nx_inc   <= e_elig && e_cpu;
    nx_dout  <= dataout;
  end

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_ack   <= 1'b0;
      m_cnt   <= 0;
      m_rdata <= 32'h0;
    end else begin
      m_ack <= nx_ld;
      if (nx_ld) begin
        m_rdata <= nx_dout;
        m_cnt   <= 0;
      end else if (nx_inc && (m_cnt < int'(SM))) begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  initial begin
    resetn = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 32'h55; cpu_wdata = 32'h0;
    ld_req = 1; ld_we = 1; ld_addr = 32'h300; ld_wdata = 32'hDEAD; dataout = 32'h0;

    // Reset: loader ignored, registers cleared.
    step(); step();
    chk("rst_mwmem", {31'b0, mwmem}, 32'h0);
    chk("rst_malu", malu, 32'h55);
    chk("rst_ack", {31'b0, ld_ack}, 32'h0);
    chk("rst_rdata", ld_rdata, 32'h0);
    step();
    resetn = 1; ld_req = 0; ld_we = 0;
    step();

    // Plain CPU write, then CPU read.
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hA5A5A5A5;
    #1;
    chk("cpu_wr_mwmem", {31'b0, mwmem}, 32'h1);
    chk("cpu_wr_malu", malu, 32'h10);
    chk("cpu_wr_mb", mb, 32'hA5A5A5A5);
    chk("cpu_wr_stall", {31'b0, cpu_stall}, 32'h0);
    step();
    cpu_we = 0; dataout = 32'hCAFE;
    #1;
    chk("cpu_rd_data", cpu_rdata, 32'hCAFE);
    step();

    // Uncontested loader read: grant N, ack N+1, idle N+2.
    cpu_req = 0; ld_req = 1; ld_we = 0; ld_addr = 32'h20; dataout = 32'h1234;
    #1;
    chk("ld_rd_malu", malu, 32'h20);
    chk("ld_rd_mwmem", {31'b0, mwmem}, 32'h0);
    step();
    ld_req = 0; dataout = 32'h0;
    #1;
    chk("ld_rd_ack", {31'b0, ld_ack}, 32'h1);
    chk("ld_rd_data", ld_rdata, 32'h1234);
    step();
    #1;
    chk("ld_rd_ack_off", {31'b0, ld_ack}, 32'h0);
    chk("ld_rd_data_hold", ld_rdata, 32'h1234);
    step();

    // Continuous contention: 4 CPU wins, loader wins 5th, then ack; repeats.
    cpu_req = 1; ld_req = 1; cpu_addr = 32'h40; ld_addr = 32'h60;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("starve_stall", {31'b0, cpu_stall}, {31'b0, (i == 4) || (i == 10)});
      chk("starve_ack", {31'b0, ld_ack}, {31'b0, (i == 5) || (i == 11)});
      step();
    end
    cpu_req = 0; ld_req = 0;
    step();

    // Loader request held through the ack: grants two cycles apart.
    ld_req = 1; ld_we = 1; ld_addr = 32'h24; ld_wdata = 32'h77;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("b2b_mwmem", {31'b0, mwmem}, {31'b0, (i % 2) == 0});
      chk("b2b_ack", {31'b0, ld_ack}, {31'b0, (i % 2) == 1});
      step();
    end
    ld_req = 0; ld_we = 0;
    step();

    // Reset pulse inside the ack cycle.
    ld_req = 1; ld_addr = 32'h44; dataout = 32'h5555;
    step();
    ld_req = 0;
    #1;
    chk("rstack_pre", {31'b0, ld_ack}, 32'h1);
    resetn = 0;
    #1;
    chk("rstack_ack", {31'b0, ld_ack}, 32'h0);
    chk("rstack_rdata", ld_rdata, 32'h0);
    resetn = 1;
    step();
    #1;
    chk("rstack_no_regrant", {31'b0, ld_ack}, 32'h0);
    step();

    // Reset clears a partially built starvation count.
    cpu_req = 1; ld_req = 1;
    step(); step(); step();
    resetn = 0;
    #1;
    resetn = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rst_starve_stall", {31'b0, cpu_stall}, {31'b0, i == 4});
      step();
    end

    // CPU I/O write contested by a loader write: one coherent write per cycle.
    cpu_we = 1; cpu_addr = 32'h80; cpu_wdata = 32'h11111111;
    ld_we = 1; ld_addr = 32'h84; ld_wdata = 32'h22222222;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("io_mwmem", {31'b0, mwmem}, 32'h1);
      chk("io_pair", {31'b0, ((malu == 32'h80) && (mb == 32'h11111111)) ||
                             ((malu == 32'h84) && (mb == 32'h22222222))}, 32'h1);
      chk("io_stall", {31'b0, cpu_stall}, {31'b0, i == 5});
      if (cpu_stall) chk("io_ld_src", malu, 32'h84);
      step();
    end
    cpu_req = 0; ld_req = 0; cpu_we = 0; ld_we = 0;
    step(); step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
